// File: rtl/pcie_tx_pkg.sv
// Shared types and defaults for the PCIe TX arbiter.
`timescale 1ns/1ps
package pcie_tx_pkg;

  localparam int unsigned BUF_AV_MIN_DEFAULT = 2;
  localparam int unsigned TUSER_W            = 4;
  localparam int unsigned BUF_AV_W           = 6;
  localparam int unsigned DROP_CNT_W         = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    CFG  = 2'd3
  } state_t;

endpackage

// File: rtl/pcie_tx_arb_if.sv
// AXI-stream style TLP channel shared by requesters and the core-facing port.
`timescale 1ns/1ps
interface pcie_tx_arb_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned KEEP_W = DATA_W / 8
) ();
  import pcie_tx_pkg::*;

  logic [DATA_W-1:0]  tdata;
  logic [KEEP_W-1:0]  tkeep;
  logic [TUSER_W-1:0] tuser;
  logic               tlast;
  logic               tvalid;
  logic               tready;

  modport master (output tdata, tkeep, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tuser, tlast, tvalid, output tready);

endinterface

// File: rtl/pcie_tx_rr_sel.sv
// Two-way round-robin pick with a last-grant pointer.
`timescale 1ns/1ps
module pcie_tx_rr_sel (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic       pick_c
);

  logic last;

  // Pointer holds the requester that finished a packet most recently; after
  // reset it points at src1 so that src0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (upd) begin
      last <= upd_idx;
    end
  end

  // Alternate on contention, otherwise pick the only requester present.
  always_comb begin
    pick_c = 1'b0;
    if (req == 2'b11) begin
      pick_c = ~last;
    end else if (req[1]) begin
      pick_c = 1'b1;
    end
  end

endmodule

// File: rtl/pcie_tx_arb.sv
// Merges two TLP requesters and core config-completion access onto the PCIe TX stream.
`timescale 1ns/1ps
module pcie_tx_arb
  import pcie_tx_pkg::*;
#(
  parameter int unsigned PCIE_DATA_WIDTH = 64,
  parameter int unsigned PCIE_KEEP_WIDTH = PCIE_DATA_WIDTH / 8,
  parameter int unsigned BUF_AV_MIN      = BUF_AV_MIN_DEFAULT
) (
  input  logic                  pcie_clk_in,
  input  logic                  pcie_reset_out,
  input  logic                  pcie_link_up,
  pcie_tx_arb_if.slave          src0,
  pcie_tx_arb_if.slave          src1,
  pcie_tx_arb_if.master         s_axis_tx,
  input  logic [BUF_AV_W-1:0]   tx_buf_av,
  input  logic                  tx_terr_drop,
  input  logic                  tx_cfg_req,
  output logic                  tx_cfg_gnt,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam logic [BUF_AV_W-1:0] BUF_AV_MIN_L = BUF_AV_W'(BUF_AV_MIN);

  state_t state;
  state_t state_nxt;

  logic [1:0] req;
  logic       can_start;
  logic       pick;
  logic       upd;
  logic       upd_idx;

  logic [PCIE_DATA_WIDTH-1:0] tx_data;
  logic [PCIE_KEEP_WIDTH-1:0] tx_keep;
  logic [TUSER_W-1:0]         tx_user;
  logic                       tx_last;
  logic                       tx_valid;
  logic                       rdy0;
  logic                       rdy1;

  assign req       = {src1.tvalid, src0.tvalid};
  assign can_start = (tx_buf_av >= BUF_AV_MIN_L) && (req != 2'b00);

  pcie_tx_rr_sel u_rr_sel (
    .clk     (pcie_clk_in),
    .rst     (pcie_reset_out),
    .req     (req),
    .upd     (upd),
    .upd_idx (upd_idx),
    .pick_c  (pick)
  );

  // State register.
  always_ff @(posedge pcie_clk_in) begin
    if (pcie_reset_out) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: config wins in IDLE, grants are held to tlast, link loss aborts.
  always_comb begin
    state_nxt = state;
    upd       = 1'b0;
    upd_idx   = 1'b0;
    case (state)
      IDLE: begin
        if (tx_cfg_req) begin
          state_nxt = CFG;
        end else if (can_start) begin
          state_nxt = pick ? GNT1 : GNT0;
        end
      end
      GNT0: begin
        if (src0.tvalid && s_axis_tx.tready && src0.tlast) begin
          state_nxt = IDLE;
          upd       = 1'b1;
          upd_idx   = 1'b0;
        end
      end
      GNT1: begin
        if (src1.tvalid && s_axis_tx.tready && src1.tlast) begin
          state_nxt = IDLE;
          upd       = 1'b1;
          upd_idx   = 1'b1;
        end
      end
      CFG: begin
        if (!tx_cfg_req) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (!pcie_link_up) begin
      state_nxt = IDLE;
      upd       = 1'b0;
    end
  end

  // Registered config grant and wrapping drop counter.
  always_ff @(posedge pcie_clk_in) begin
    if (pcie_reset_out) begin
      tx_cfg_gnt <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      tx_cfg_gnt <= (state_nxt == CFG);
      if (tx_terr_drop) begin
        drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

  // Stream mux: only the granted requester is connected, everything is
  // forced low outside a grant and while reset is asserted.
  always_comb begin
    tx_data  = '0;
    tx_keep  = '0;
    tx_user  = '0;
    tx_last  = 1'b0;
    tx_valid = 1'b0;
    rdy0     = 1'b0;
    rdy1     = 1'b0;
    if (!pcie_reset_out) begin
      case (state)
        GNT0: begin
          tx_data  = src0.tdata;
          tx_keep  = src0.tkeep;
          tx_user  = src0.tuser;
          tx_last  = src0.tlast;
          tx_valid = src0.tvalid;
          rdy0     = s_axis_tx.tready;
        end
        GNT1: begin
          tx_data  = src1.tdata;
          tx_keep  = src1.tkeep;
          tx_user  = src1.tuser;
          tx_last  = src1.tlast;
          tx_valid = src1.tvalid;
          rdy1     = s_axis_tx.tready;
        end
        default: ;
      endcase
    end
  end

  assign s_axis_tx.tdata  = tx_data;
  assign s_axis_tx.tkeep  = tx_keep;
  assign s_axis_tx.tuser  = tx_user;
  assign s_axis_tx.tlast  = tx_last;
  assign s_axis_tx.tvalid = tx_valid;
  assign src0.tready      = rdy0;
  assign src1.tready      = rdy1;

endmodule

// File: tb/tb_pcie_tx_arb.sv
// Bench for pcie_tx_arb: arbitration vector table, directed corner sequences,
// randomized traffic against an owner-based reference model, drop counter wrap.
`timescale 1ns/1ps
module tb_pcie_tx_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, link, terr, cfg, cfg_gnt, m_rdy;
  logic [5:0]  buf_av;
  logic [15:0] drop_cnt;

  pcie_tx_arb_if #(.DATA_W(64), .KEEP_W(8)) s0 ();
  pcie_tx_arb_if #(.DATA_W(64), .KEEP_W(8)) s1 ();
  pcie_tx_arb_if #(.DATA_W(64), .KEEP_W(8)) m ();

  assign m.tready = m_rdy;

  pcie_tx_arb #(.PCIE_DATA_WIDTH(64), .PCIE_KEEP_WIDTH(8), .BUF_AV_MIN(2)) dut (
    .pcie_clk_in    (clk),
    .pcie_reset_out (rst),
    .pcie_link_up   (link),
    .src0           (s0),
    .src1           (s1),
    .s_axis_tx      (m),
    .tx_buf_av      (buf_av),
    .tx_terr_drop   (terr),
    .tx_cfg_req     (cfg),
    .tx_cfg_gnt     (cfg_gnt),
    .drop_cnt       (drop_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the TX path (-1 nobody, 0/1 requester, 2 core)
  // and which requester should win the next tie.
  int          owner, favour;
  logic [15:0] exp_drop;

  // Requester behaviour: packets of src_len beats, src_left packets to send.
  bit         src_vld[2], src_last[2], hs[2];
  int         src_beat[2], src_len[2], src_pid[2], src_left[2];
  logic [63:0] src_data[2];
  logic [7:0]  src_keep[2];
  logic [3:0]  src_user[2];
  bit          lnk_prev;
  int          rdy_mode, gcyc;
  int          beats_out[2];
  int          log_src[$], log_cyc[$];

  typedef struct {
    bit         v0, v1, cfg, link;
    logic [5:0] buf_av;
    bit         r0, r1, gnt;
  } vec_t;
  vec_t vt[9];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, gcyc);
    end
  endtask

  task automatic bfm_drive();
    for (int s = 0; s < 2; s++) begin
      src_data[s] = {8'(s), 40'(src_pid[s]), 16'(src_beat[s])};
      src_keep[s] = 8'(src_pid[s] * 3 + s + 1);
      src_user[s] = 4'(src_beat[s]);
      src_last[s] = (src_beat[s] == src_len[s] - 1);
    end
    s0.tvalid = src_vld[0]; s0.tdata = src_data[0]; s0.tkeep = src_keep[0];
    s0.tuser  = src_user[0]; s0.tlast = src_last[0];
    s1.tvalid = src_vld[1]; s1.tdata = src_data[1]; s1.tkeep = src_keep[1];
    s1.tuser  = src_user[1]; s1.tlast = src_last[1];
  endtask

  task automatic model_check();
    logic ev, el, er0, er1;
    logic [63:0] ed;
    logic [7:0]  ek;
    logic [3:0]  eu;
    ev = 1'b0; el = 1'b0; er0 = 1'b0; er1 = 1'b0; ed = '0; ek = '0; eu = '0;
    if (!rst && (owner == 0 || owner == 1)) begin
      ev  = src_vld[owner];
      ed  = src_data[owner];
      ek  = src_keep[owner];
      eu  = src_user[owner];
      el  = src_last[owner];
      er0 = (owner == 0) && m_rdy;
      er1 = (owner == 1) && m_rdy;
    end
    chk("tvalid", 64'(m.tvalid), 64'(ev));
    chk("tdata", m.tdata, ed);
    chk("tkeep", 64'(m.tkeep), 64'(ek));
    chk("tuser", 64'(m.tuser), 64'(eu));
    chk("tlast", 64'(m.tlast), 64'(el));
    chk("src0_tready", 64'(s0.tready), 64'(er0));
    chk("src1_tready", 64'(s1.tready), 64'(er1));
    chk("tx_cfg_gnt", 64'(cfg_gnt), 64'(owner == 2));
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
  endtask

  task automatic model_step();
    hs[0] = src_vld[0] && (s0.tready === 1'b1);
    hs[1] = src_vld[1] && (s1.tready === 1'b1);
    for (int s = 0; s < 2; s++) begin
      if (hs[s]) begin
        beats_out[s]++;
        if (src_beat[s] == 0) begin
          log_src.push_back(s);
          log_cyc.push_back(gcyc);
        end
      end
    end
    lnk_prev = link;
    if (rst) begin
      owner = -1; favour = 0; exp_drop = '0;
    end else begin
      if (terr) exp_drop = exp_drop + 16'd1;
      if (!link) begin
        owner = -1;
      end else if (owner == -1) begin
        if (cfg) owner = 2;
        else if (buf_av >= 6'd2 && (src_vld[0] || src_vld[1]))
          owner = (src_vld[0] && src_vld[1]) ? favour : (src_vld[0] ? 0 : 1);
      end else if (owner == 2) begin
        if (!cfg) owner = -1;
      end else if (src_vld[owner] && m_rdy && src_last[owner]) begin
        favour = 1 - owner;
        owner  = -1;
      end
    end
  endtask

  task automatic bfm_advance(bit rnd);
    for (int s = 0; s < 2; s++) begin
      if (!lnk_prev) begin
        src_beat[s] = 0;
        if (src_vld[s]) src_pid[s]++;
      end else if (hs[s]) begin
        if (src_beat[s] == src_len[s] - 1) begin
          src_beat[s] = 0; src_pid[s]++; src_left[s]--; src_vld[s] = 1'b0;
          if (rnd) src_len[s] = int'($urandom_range(1, 5));
        end else begin
          src_beat[s]++;
        end
      end
      if (src_left[s] <= 0) src_vld[s] = 1'b0;
      else if (!src_vld[s]) src_vld[s] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    end
  endtask

  task automatic cyc(bit rnd);
    bfm_drive();
    #2;
    model_check();
    model_step();
    @(posedge clk); #1;
    gcyc++;
    bfm_advance(rnd);
  endtask

  task automatic run(int n, bit rnd);
    for (int c = 0; c < n; c++) begin
      if (rnd) begin
        cfg    = cfg  ? ($urandom_range(0, 3) != 0)  : ($urandom_range(0, 39) == 0);
        link   = link ? ($urandom_range(0, 99) != 0) : ($urandom_range(0, 2) == 0);
        buf_av = 6'($urandom_range(0, 7));
        m_rdy  = ($urandom_range(0, 3) != 0);
        terr   = ($urandom_range(0, 9) == 0);
      end else if (rdy_mode == 1) begin
        m_rdy = ((gcyc % 2) == 1);
      end
      cyc(rnd);
    end
  endtask

  task automatic settle();
    bfm_drive();
    #1;
  endtask

  task automatic src_go(int s, int n, int l);
    src_left[s] = n; src_len[s] = l; src_beat[s] = 0; src_vld[s] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg = 1'b0; link = 1'b1; terr = 1'b0; buf_av = 6'd8;
    m_rdy = 1'b1; rdy_mode = 0;
    for (int s = 0; s < 2; s++) begin
      src_vld[s] = 1'b0; src_beat[s] = 0; src_len[s] = 1; src_pid[s] = 0;
      src_left[s] = 0; hs[s] = 1'b0; beats_out[s] = 0;
    end
    bfm_drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    owner = -1; favour = 0; exp_drop = '0; lnk_prev = 1'b1; gcyc = 0;
    log_src.delete(); log_cyc.delete();
  endtask

  initial begin
    int exp_src[4];
    int exp_cyc[4];
    exp_src = '{0, 1, 0, 1};
    exp_cyc = '{1, 4, 7, 10};
    rst = 1'b1;
    gcyc = 0;
    @(posedge clk); #1;

    // Reset state.
    do_reset();
    settle();
    chk("reset_tvalid", 64'(m.tvalid), 64'd0);
    chk("reset_cfg_gnt", 64'(cfg_gnt), 64'd0);
    chk("reset_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("reset_src0_tready", 64'(s0.tready), 64'd0);

    // Arbitration decisions from IDLE right after reset.
    vt[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'd2,  1'b1, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd2,  1'b0, 1'b1, 1'b0};
    vt[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 6'd8,  1'b1, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'd8,  1'b0, 1'b0, 1'b1};
    vt[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'd1,  1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd63, 1'b0, 1'b0, 1'b0};
    vt[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd0,  1'b0, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd63, 1'b0, 1'b0, 1'b0};
    vt[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'd63, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      do_reset();
      if (vt[i].v0) src_go(0, 1, 2);
      if (vt[i].v1) src_go(1, 1, 2);
      cfg = vt[i].cfg; link = vt[i].link; buf_av = vt[i].buf_av;
      cyc(1'b0);
      settle();
      chk($sformatf("vec%0d_src0_tready", i), 64'(s0.tready), 64'(vt[i].r0));
      chk($sformatf("vec%0d_src1_tready", i), 64'(s1.tready), 64'(vt[i].r1));
      chk($sformatf("vec%0d_cfg_gnt", i), 64'(cfg_gnt), 64'(vt[i].gnt));
    end

    // Single source, 3-beat packet.
    do_reset();
    src_go(0, 1, 3);
    run(6, 1'b0);
    chk("single_pkts", 64'(log_src.size()), 64'd1);
    if (log_cyc.size() > 0) chk("single_first_beat_cycle", 64'(log_cyc[0]), 64'd1);
    chk("single_beats", 64'(beats_out[0]), 64'd3);

    // Contention: grant order alternates with one IDLE cycle between packets.
    do_reset();
    src_go(0, 2, 2);
    src_go(1, 2, 2);
    run(14, 1'b0);
    chk("contention_pkts", 64'(log_src.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_src.size(); i++) begin
      chk($sformatf("contention_src%0d", i), 64'(log_src[i]), 64'(exp_src[i]));
      chk($sformatf("contention_cyc%0d", i), 64'(log_cyc[i]), 64'(exp_cyc[i]));
    end

    // Backpressure on a 4-beat src1 packet.
    do_reset();
    src_go(1, 1, 4);
    rdy_mode = 1;
    run(11, 1'b0);
    rdy_mode = 0;
    chk("bp_beats", 64'(beats_out[1]), 64'd4);
    chk("bp_pkts", 64'(log_src.size()), 64'd1);

    // Config request blocks a pending requester until released.
    do_reset();
    cfg = 1'b1;
    src_go(0, 1, 2);
    run(3, 1'b0);
    settle();
    chk("cfg_gnt_held", 64'(cfg_gnt), 64'd1);
    chk("cfg_src0_blocked", 64'(s0.tready), 64'd0);
    chk("cfg_no_beats", 64'(beats_out[0]), 64'd0);
    cfg = 1'b0;
    run(6, 1'b0);
    if (log_cyc.size() > 0) chk("cfg_release_cycle", 64'(log_cyc[0]), 64'd5);
    chk("cfg_release_beats", 64'(beats_out[0]), 64'd2);

    // Buffer gating at packet start.
    do_reset();
    buf_av = 6'd1;
    src_go(0, 1, 1);
    run(4, 1'b0);
    chk("buf1_no_grant", 64'(log_src.size()), 64'd0);
    buf_av = 6'd2;
    run(3, 1'b0);
    chk("buf2_grant", 64'(log_src.size()), 64'd1);
    if (log_cyc.size() > 0) chk("buf2_grant_cycle", 64'(log_cyc[0]), 64'd5);

    // Link drop at beat 2 of 4.
    do_reset();
    src_go(0, 1, 4);
    run(2, 1'b0);
    link = 1'b0;
    run(1, 1'b0);
    link = 1'b1;
    settle();
    chk("linkdrop_tvalid", 64'(m.tvalid), 64'd0);
    chk("linkdrop_src0_tready", 64'(s0.tready), 64'd0);
    run(6, 1'b0);
    chk("linkdrop_beats", 64'(beats_out[0]), 64'd6);

    // Reset mid-packet.
    do_reset();
    src_go(0, 1, 4);
    run(2, 1'b0);
    rst = 1'b1;
    run(1, 1'b0);
    rst = 1'b0;
    settle();
    chk("rstmid_tvalid", 64'(m.tvalid), 64'd0);
    chk("rstmid_src0_tready", 64'(s0.tready), 64'd0);
    chk("rstmid_cfg_gnt", 64'(cfg_gnt), 64'd0);
    run(6, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    src_go(0, 100000, 3);
    src_go(1, 100000, 2);
    run(3000, 1'b1);
    chk("random_progress", 64'((beats_out[0] > 0) && (beats_out[1] > 0)), 64'd1);

    // Drop counter wrap.
    do_reset();
    terr = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    chk("drop_cnt_ffff", 64'(drop_cnt), 64'hFFFF);
    repeat (2) @(posedge clk);
    #1;
    chk("drop_cnt_wrap", 64'(drop_cnt), 64'd1);
    terr = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pcie_tx_arb.md
PCIE_TX_ARB -- requirements
Module: pcie_tx_arb

Interface
REQ-001 Parameter PCIE_DATA_WIDTH, default 64, TX data width in bits.
REQ-002 Parameter PCIE_KEEP_WIDTH, default PCIE_DATA_WIDTH/8, byte-keep width.
REQ-003 Parameter BUF_AV_MIN, default 2, minimum tx_buf_av required to start a packet.
REQ-004 pcie_clk_in  input  1  sole clock; all logic on the rising edge.
REQ-005 pcie_reset_out  input  1  reset, synchronous and active-high.
REQ-006 pcie_link_up  input  1  link-up status from the core.
REQ-007 src0_tdata/src0_tkeep/src0_tuser/src0_tlast/src0_tvalid  input  PCIE_DATA_WIDTH/PCIE_KEEP_WIDTH/4/1/1  requester 0 TLP stream.
REQ-008 src0_tready  output  1  requester 0 accept.
REQ-009 src1_tdata/src1_tkeep/src1_tuser/src1_tlast/src1_tvalid  input  same widths  requester 1 TLP stream.
REQ-010 src1_tready  output  1  requester 1 accept.
REQ-011 s_axis_tx_tdata/tkeep/tuser/tlast/tvalid  output  PCIE_DATA_WIDTH/PCIE_KEEP_WIDTH/4/1/1  merged stream to the core.
REQ-012 s_axis_tx_tready  input  1  core accept.
REQ-013 tx_buf_av  input  6  free core TX buffers.
REQ-014 tx_terr_drop  input  1  core dropped a TLP.
REQ-015 tx_cfg_req  input  1  core requests the TX path for a config completion.
REQ-016 tx_cfg_gnt  output  1  grant of the TX path to the core.
REQ-017 drop_cnt  output  16  count of tx_terr_drop pulses.

Function
REQ-018 The FSM SHALL have states IDLE, GNT0, GNT1, CFG.
REQ-019 In IDLE with pcie_link_up=1, tx_cfg_req=1: next state CFG; CFG SHALL take priority over both requesters.
REQ-020 In IDLE with pcie_link_up=1, tx_cfg_req=0, tx_buf_av>=BUF_AV_MIN and any srcN_tvalid=1: next state GNT0 or GNT1 by round-robin.
REQ-021 Round-robin: a 1-bit last-grant pointer favours the requester not granted last; on a tie after reset, src0 wins.
REQ-022 Grant latency SHALL be exactly one cycle: a request seen in IDLE at cycle N allows its first beat to transfer at N+1.
REQ-023 In GNTk: s_axis_tx_* = srck_* and srck_tready = s_axis_tx_tready, combinationally; the other requester's tready = 0.
REQ-024 In GNTk, a beat with srck_tvalid & s_axis_tx_tready & srck_tlast SHALL return the FSM to IDLE the next cycle and set the pointer to k.
REQ-025 A grant SHALL be held until tlast; no preemption mid-packet by tx_cfg_req or the other requester.
REQ-026 Outside GNTk: s_axis_tx_tvalid=0, tlast=0, tdata/tkeep/tuser=0, both srcN_tready=0.
REQ-027 tx_cfg_gnt SHALL be registered and equal 1 only in CFG.
REQ-028 CFG SHALL return to IDLE the cycle after tx_cfg_req=0 is sampled.
REQ-029 pcie_link_up=0 in any state SHALL force IDLE next cycle. A packet in flight is abandoned; requesters flush their own state.
REQ-030 tx_buf_av is checked only at packet start; a drop below BUF_AV_MIN mid-packet does not stall the arbiter beyond s_axis_tx_tready.
REQ-031 drop_cnt SHALL increment by 1 per cycle with tx_terr_drop=1 and wrap from 0xFFFF to 0x0000.

Reset
REQ-032 On pcie_reset_out=1 at a clock edge: state IDLE, pointer favouring src0, tx_cfg_gnt=0, drop_cnt=0.
REQ-033 Reset asserted mid-packet SHALL take effect on the next edge regardless of handshake state.
REQ-034 All derived outputs SHALL be 0 during reset, including s_axis_tx_tvalid and srcN_tready.

Structure
REQ-035 A shared package pcie_tx_pkg SHALL hold the state enum (IDLE, GNT0, GNT1, CFG) and the default BUF_AV_MIN.
REQ-036 The block SHALL be a single FSM plus a mux, with one sub-module pcie_tx_rr_sel implementing the 2-way round-robin pick and the pointer update.

Verification
REQ-037 Single source: src0 sends a 3-beat packet, tready=1 -> tvalid rises 1 cycle after request; 3 beats pass unmodified; IDLE follows tlast.
REQ-038 Contention: both sources hold 2-beat packets continuously -> grant order src0, src1, src0, src1; one IDLE cycle between packets.
REQ-039 Backpressure: s_axis_tx_tready toggles 1,0,1,0 over a 4-beat src1 packet -> src1_tready mirrors it; no beat lost or duplicated.
REQ-040 Config and buffer gating: tx_cfg_req=1 with src0 pending -> tx_cfg_gnt=1, src0 blocked until req=0. tx_buf_av=1 -> no grant; tx_buf_av=2 -> grant.
REQ-041 Link drop and reset mid-packet: pcie_link_up=0 at beat 2 of 4 -> IDLE next cycle, tvalid=0. pcie_reset_out=1 mid-packet -> all outputs 0 next edge.
REQ-042 Counter: 65537 tx_terr_drop pulses -> drop_cnt=1.
